// File: rtl/mdu_div_pkg.sv
// Shared constants for the iterative divider: state encoding, step count and
// the {remainder, quotient} result packing used by mdu_s2.
package mdu_div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_STEPS);

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [2*DIV_W-1:0] div_pack(input logic [DIV_W-1:0] rem,
                                                  input logic [DIV_W-1:0] quot);
    return {rem, quot};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor, keep the difference only if it did not borrow.
module mdu_div_step
  import mdu_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_nxt,
  output logic [DIV_W-1:0] quo_nxt
);

  logic [DIV_W+1:0] trial;

  // One extra top bit keeps a zero divisor from looking like a borrow when rem[31] is set.
  assign trial = {1'b0, rem, quo[DIV_W-1]} - {2'b00, divisor};

  always_comb begin
    rem_nxt = {rem[DIV_W-2:0], quo[DIV_W-1]};
    quo_nxt = {quo[DIV_W-2:0], 1'b0};
    if (!trial[DIV_W+1]) begin
      rem_nxt = trial[DIV_W-1:0];
      quo_nxt = {quo[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider (32 steps), signed or unsigned via SIGNED.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips CALC and answers one cycle after accept.
module mdu_div
  import mdu_div_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     div_opr1_i,
  input  logic [DIV_W-1:0]     div_opr2_i,
  input  logic                 div_valid_i,
  input  logic                 div_cancel_i,
  output logic                 div_rdy_o,
  output logic [2*DIV_W-1:0]   div_data_o,
  output logic                 div_ansok_o
);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_W-1:0]     rem;
  logic [DIV_W-1:0]     quo;
  logic [DIV_W-1:0]     dvs;
  logic                 q_neg;
  logic                 r_neg;
  logic [DIV_W-1:0]     rem_nxt;
  logic [DIV_W-1:0]     quo_nxt;
  logic [DIV_W-1:0]     rem_fix;
  logic [DIV_W-1:0]     quo_fix;
  logic                 s1;
  logic                 s2;
  logic                 last_step;

  function automatic logic [DIV_W-1:0] cond_neg(input logic signed [DIV_W-1:0] v,
                                                input logic neg);
    logic signed [DIV_W-1:0] n;
    n = -v;
    return neg ? n : v;
  endfunction

  assign s1        = SIGNED && div_opr1_i[DIV_W-1];
  assign s2        = SIGNED && div_opr2_i[DIV_W-1];
  assign last_step = (cnt == DIV_CNT_W'(DIV_STEPS - 1));

  mdu_div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sign correction of the final step, ahead of the result register
  always_comb begin
    quo_fix = cond_neg(quo_nxt, q_neg);
    rem_fix = cond_neg(rem_nxt, r_neg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_data_o <= '0;
    end else if (div_cancel_i) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_valid_i) begin
            quo   <= cond_neg(div_opr1_i, s1);
            dvs   <= cond_neg(div_opr2_i, s2);
            rem   <= '0;
            cnt   <= '0;
            q_neg <= s1 ^ s2;
            r_neg <= s1;
            state <= DIV_CALC;
`ifdef DIV_ZERO_FAST_EN
            if (div_opr2_i == '0) begin
              div_data_o <= div_pack(div_opr1_i, s1 ? DIV_W'(1) : '1);
              state      <= DIV_DONE;
            end
`endif
          end
        end
        DIV_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            div_data_o <= div_pack(rem_fix, quo_fix);
            state      <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign div_rdy_o   = (state == DIV_IDLE);
  assign div_ansok_o = (state == DIV_DONE);

endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div: one signed and one unsigned instance, a vector table
// plus hand-written cancel and mid-operation reset sequences.
module tb_mdu_div;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] opr1, opr2;
  logic        vld_s, vld_u, cancel;
  logic        rdy_s, rdy_u, ansok_s, ansok_u;
  logic [63:0] data_s, data_u;
  bit          sel;
  logic        rdy_m, ansok_m;
  logic [63:0] data_m;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mdu_div #(.SIGNED(1'b1)) u_div_s (
    .clk(clk), .rst_n(rst_n), .div_opr1_i(opr1), .div_opr2_i(opr2),
    .div_valid_i(vld_s), .div_cancel_i(cancel), .div_rdy_o(rdy_s),
    .div_data_o(data_s), .div_ansok_o(ansok_s)
  );

  mdu_div #(.SIGNED(1'b0)) u_div_u (
    .clk(clk), .rst_n(rst_n), .div_opr1_i(opr1), .div_opr2_i(opr2),
    .div_valid_i(vld_u), .div_cancel_i(cancel), .div_rdy_o(rdy_u),
    .div_data_o(data_u), .div_ansok_o(ansok_u)
  );

  assign rdy_m   = sel ? rdy_s   : rdy_u;
  assign ansok_m = sel ? ansok_s : ansok_u;
  assign data_m  = sel ? data_s  : data_u;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Accepts one operation on the selected instance and waits (bounded) for ansok.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] d, output int lat, output bit rdy_low);
    sel = s; opr1 = a; opr2 = b;
    if (s) vld_s = 1'b1; else vld_u = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0; vld_u = 1'b0;
    lat = -1; d = '0; rdy_low = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (rdy_m) rdy_low = 1'b0;
      if (ansok_m) begin lat = k; d = data_m; end
    end
  endtask

  initial begin
    logic [63:0] d;
    int          lat;
    bit          rl;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 33};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFF6,   32'd0,          32'h00000001, 32'hFFFFFFF6, ZLAT};
    vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005, ZLAT};
    vecs[7]  = '{1'b1, 32'd7,          32'd0,          32'hFFFFFFFF, 32'h00000007, ZLAT};
    vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
    vecs[9]  = '{1'b1, 32'd9,          32'd2,          32'h00000004, 32'h00000001, 33};
    vecs[10] = '{1'b1, 32'hFFFFFFF7,   32'd2,          32'hFFFFFFFC, 32'hFFFFFFFF, 33};

    rst_n = 1'b0; opr1 = '0; opr2 = '0; vld_s = 1'b0; vld_u = 1'b0; cancel = 1'b0; sel = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy",   {62'd0, rdy_s, rdy_u},     64'd3);
    check("reset_ansok", {62'd0, ansok_s, ansok_u}, 64'd0);
    check("reset_data_s", data_s, 64'd0);
    check("reset_data_u", data_u, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, d, lat, rl);
      check($sformatf("vec%0d_data", i), d, {vecs[i].r, vecs[i].q});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_rdy_low", i), {63'd0, rl}, 64'd1);
      @(negedge clk);
      check($sformatf("vec%0d_after", i), {62'd0, rdy_m, ansok_m}, 64'd2);
      @(posedge clk); #1;
    end

    // Cancel at T+10 of a signed 100/7, then a fresh 9/2 started at T+12
    sel = 1'b1; opr1 = 32'd100; opr2 = 32'd7; vld_s = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_idle", {62'd0, rdy_s, ansok_s}, 64'd2);
    @(posedge clk); #1;
    run_div(1'b1, 32'd9, 32'd2, d, lat, rl);
    check("cancel_restart_latency", 64'(lat), 64'd33);
    check("cancel_restart_data", d, {32'd1, 32'd4});
    @(posedge clk); #1;

    // Reset at T+5 with valid held high; next accept must run a clean 32-step op
    sel = 1'b1; opr1 = 32'd100; opr2 = 32'd7; vld_s = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_state", {62'd0, rdy_s, ansok_s}, 64'd2);
    check("midreset_data", data_s, 64'd0);
    lat = -1; d = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (ansok_s) begin lat = k; d = data_s; vld_s = 1'b0; end
    end
    check("midreset_latency", 64'(lat), 64'd33);
    check("midreset_data_after", d, {32'd2, 32'd14});
    @(negedge clk);
    check("midreset_no_double_ansok", {63'd0, ansok_s}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
